// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory read handshake plus the
// instruction/PC exchange with the control unit.
// master: the fetch unit side. slave: the memory/control side.
interface fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        retire;
  logic        set_pc;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic        fetch_fault;

  modport master (
    output mem_req, mem_addr, instr, instr_valid, pc, fetch_fault,
    input  mem_ack, mem_rdata, retire, set_pc, jump_target
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_valid, pc, fetch_fault,
    output mem_ack, mem_rdata, retire, set_pc, jump_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at pc, latches it on ack, holds
// it for the control unit until retire, then advances pc (or jumps).
// Optional build macro FETCH_TIMEOUT_EN adds a fetch watchdog that parks the
// unit in a sticky FAULT state when memory fails to ack within
// TIMEOUT_CYCLES cycles; only reset leaves FAULT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc_r;
  logic [15:0] instr_r;
  logic        valid_r;

`ifdef FETCH_TIMEOUT_EN
  logic        fault_r;
  logic [7:0]  wait_cnt;

  // Fetch FSM with watchdog: ack on the limit edge beats the fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc_r     <= RESET_PC;
      instr_r  <= 16'h0000;
      valid_r  <= 1'b0;
      fault_r  <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_ack) begin
            instr_r <= bus.mem_rdata;
            valid_r <= 1'b1;
            state   <= HOLD;
          end else if (wait_cnt == TIMEOUT_CYCLES - 8'd1) begin
            fault_r <= 1'b1;
            state   <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (bus.retire) begin
            pc_r     <= bus.set_pc ? bus.jump_target : pc_r + 16'd1;
            valid_r  <= 1'b0;
            wait_cnt <= 8'd0;
            state    <= FETCH;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.fetch_fault = fault_r;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;

  // Fetch FSM without watchdog: FETCH waits for ack indefinitely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc_r    <= RESET_PC;
      instr_r <= 16'h0000;
      valid_r <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_ack) begin
            instr_r <= bus.mem_rdata;
            valid_r <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.retire) begin
            pc_r    <= bus.set_pc ? bus.jump_target : pc_r + 16'd1;
            valid_r <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.fetch_fault = 1'b0;
`endif

  // Request is masked by rst so nothing is issued while reset is held.
  assign bus.mem_req     = (state == FETCH) && !rst;
  assign bus.mem_addr    = pc_r;
  assign bus.pc          = pc_r;
  assign bus.instr       = instr_r;
  assign bus.instr_valid = valid_r;

endmodule
